// File: rtl/branch_predict_table.sv
// branch_predict_table
// Direction predictor for the fetch stage: a table of saturating counters
// indexed by PC, optionally XORed with a global branch history (gshare).
// IF looks up a prediction every cycle; EX trains the table with resolved
// outcomes and repairs the speculative history after a mispredict.
// Saturating statistics counters track resolved branches and mispredicts.

module branch_predict_table #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter int STAT_WIDTH = 32,
    localparam int GHR_W     = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_taken,
    output logic [GHR_W-1:0]      pred_ghr,

    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic [GHR_W-1:0]      upd_ghr,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,

    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Weakly-not-taken: MSB clear, all lower bits set (01 for 2-bit counters).
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_BITS-1:0]   counters [ENTRIES];
    logic [GHR_W-1:0]      ghr;

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_old;
    logic [CTR_BITS-1:0]   upd_new;
    logic                  recover;
    logic [GHR_W-1:0]      ghr_next;
    logic [STAT_WIDTH-1:0] branches_next;
    logic [STAT_WIDTH-1:0] mispredicts_next;

    // Only the word-aligned index bits of the PC reach the table; the rest
    // of the PC is deliberately ignored (aliasing is accepted).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[PC_WIDTH-1:INDEX_BITS+2],  upd_pc[1:0],
                              upd_ghr};

    // Zero-extends the live history bits to index width. With no history
    // configured this yields all zeros and the table is purely bimodal.
    function automatic logic [INDEX_BITS-1:0] hist_bits(input logic [GHR_W-1:0] h);
        logic [INDEX_BITS-1:0] x;
        x = '0;
        for (int i = 0; i < GHR_BITS; i++) begin
            x[i] = h[i];
        end
        return x;
    endfunction

    // Table index: PC word index XORed with the history.
    function automatic logic [INDEX_BITS-1:0] table_index(input logic [PC_WIDTH-1:0] pc,
                                                          input logic [GHR_W-1:0]    h);
        return pc[INDEX_BITS+1:2] ^ hist_bits(h);
    endfunction

    // Shifts one outcome into the history LSB, dropping the oldest bit.
    // Written as a loop so a one-bit history needs no special case.
    function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h,
                                                  input logic             b);
        logic [GHR_W-1:0] s;
        s    = '0;
        s[0] = b;
        for (int i = 1; i < GHR_W; i++) begin
            s[i] = h[i-1];
        end
        return s;
    endfunction

    // Lookup path: zero latency and independent of pred_valid, so fetch can
    // use the prediction in the same cycle it presents the PC.
    always_comb begin
        pred_idx   = table_index(pred_pc, ghr);
        pred_taken = counters[pred_idx][CTR_BITS-1];
        pred_ghr   = ghr;
    end

    // Training path: saturating step of the entry addressed by the history
    // that was live when the branch was predicted, not the current one.
    always_comb begin
        upd_idx = table_index(upd_pc, upd_ghr);
        upd_old = counters[upd_idx];
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != CTR_MAX) begin
                upd_new = upd_old + CTR_ONE;
            end
        end else begin
            if (upd_old != CTR_MIN) begin
                upd_new = upd_old - CTR_ONE;
            end
        end
    end

    // History next-state: mispredict repair outranks the speculative shift,
    // because the fetch that would have shifted is being squashed.
    always_comb begin
        recover  = upd_valid & upd_mispredict;
        ghr_next = ghr;
        if (GHR_BITS == 0) begin
            ghr_next = '0;
        end else if (recover) begin
            ghr_next = shift_in(upd_ghr, upd_taken);
        end else if (pred_valid) begin
            ghr_next = shift_in(ghr, pred_taken);
        end
    end

    // Statistics next-state: increment but stick at all-ones.
    always_comb begin
        branches_next    = stat_branches;
        mispredicts_next = stat_mispredicts;
        if (upd_valid && (stat_branches != STAT_MAX)) begin
            branches_next = stat_branches + STAT_ONE;
        end
        if (recover && (stat_mispredicts != STAT_MAX)) begin
            mispredicts_next = stat_mispredicts + STAT_ONE;
        end
    end

    // Counter table: all entries weakly-not-taken on reset, one write per
    // resolved branch; a same-cycle lookup sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            counters[upd_idx] <= upd_new;
        end
    end

    // Global history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= branches_next;
            stat_mispredicts <= mispredicts_next;
        end
    end

endmodule

// File: tb/tb_branch_predict_table.sv
// tb_branch_predict_table
// Drives a gshare instance (4-bit history, 32-bit stats) and a bimodal
// instance (no history, 3-bit stats so saturation is reachable) with the
// same stimulus and compares both against a table-of-integers model.

module tb_branch_predict_table;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        g_taken;
    logic [3:0]  g_ghr;
    logic [31:0] g_branches;
    logic [31:0] g_mispredicts;

    logic        b_taken;
    logic [0:0]  b_ghr;
    logic [0:0]  b_upd_ghr;
    logic [2:0]  b_branches;
    logic [2:0]  b_mispredicts;

    int checkCount = 0;
    int errorCount = 0;

    // Model state: index 0 = gshare instance, 1 = bimodal instance
    int    tblM   [2][64];
    int    ghrM   [2];
    longint brM   [2];
    longint misM  [2];
    int    gbits  [2] = '{4, 0};
    longint statMax [2] = '{64'hFFFF_FFFF, 64'd7};

    assign b_upd_ghr = upd_ghr[0:0];

    branch_predict_table dut_g (
        .clk              (clk),
        .reset            (reset),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (g_taken),
        .pred_ghr         (g_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_ghr          (upd_ghr),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (g_branches),
        .stat_mispredicts (g_mispredicts)
    );

    branch_predict_table #(.GHR_BITS(0), .STAT_WIDTH(3)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (b_taken),
        .pred_ghr         (b_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_ghr          (b_upd_ghr),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (b_branches),
        .stat_mispredicts (b_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelIdx(input logic [31:0] pc, input int h, input int gb);
        return ((pc >> 2) % 64) ^ (h % (1 << gb));
    endfunction

    function automatic int modelPred(input int k);
        return (tblM[k][modelIdx(pred_pc, ghrM[k], gbits[k])] >= 2) ? 1 : 0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) tblM[k][i] = 1;
            ghrM[k] = 0;
            brM[k]  = 0;
            misM[k] = 0;
        end
    endtask

    // Advances the model by one clock using the currently driven inputs.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int pt;
            int e;
            int mask;
            pt   = modelPred(k);
            mask = (1 << gbits[k]) - 1;
            if (upd_valid) begin
                e = modelIdx(upd_pc, int'(upd_ghr), gbits[k]);
                if (upd_taken) tblM[k][e] = (tblM[k][e] < 3) ? tblM[k][e] + 1 : 3;
                else           tblM[k][e] = (tblM[k][e] > 0) ? tblM[k][e] - 1 : 0;
                if (brM[k] < statMax[k]) brM[k]++;
                if (upd_mispredict && misM[k] < statMax[k]) misM[k]++;
            end
            if (upd_valid && upd_mispredict)
                ghrM[k] = ((int'(upd_ghr) << 1) | int'(upd_taken)) & mask;
            else if (pred_valid)
                ghrM[k] = ((ghrM[k] << 1) | pt) & mask;
        end
    endtask

    task automatic checkAll();
        checkOutput("g_taken",       g_taken,       modelPred(0));
        checkOutput("g_ghr",         g_ghr,         ghrM[0]);
        checkOutput("g_branches",    g_branches,    brM[0]);
        checkOutput("g_mispredicts", g_mispredicts, misM[0]);
        checkOutput("b_taken",       b_taken,       modelPred(1));
        checkOutput("b_ghr",         b_ghr,         0);
        checkOutput("b_branches",    b_branches,    brM[1]);
        checkOutput("b_mispredicts", b_mispredicts, misM[1]);
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then steps the model
    // at the rising edge. Returns 1 time unit after that edge.
    task automatic applyStimulus(input logic pv, input logic [31:0] ppc,
                                 input logic uv, input logic [31:0] upc,
                                 input logic [3:0] ughr, input logic ut, input logic um);
        pred_valid     = pv;
        pred_pc        = ppc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_ghr        = ughr;
        upd_taken      = ut;
        upd_mispredict = um;
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic peekPc(input logic [31:0] pc);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        pred_pc    = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_g_taken", g_taken, 0);
        checkOutput("rst_g_ghr",   g_ghr,   0);
        reset = 1'b0;

        // Untrained table predicts not taken; one taken update flips pc 0x40 only
        applyStimulus(0, 32'h0000_1234, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h0000_0044, 1, 32'h40, 4'h0, 1, 0);
        peekPc(32'h40);
        checkOutput("t1_b_taken_40", b_taken, 1);
        peekPc(32'h44);
        checkOutput("t1_b_taken_44", b_taken, 0);

        // Saturation up, then down past the floor
        repeat (5) applyStimulus(0, 32'h40, 1, 32'h40, 4'h0, 1, 0);
        applyStimulus(0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        peekPc(32'h40);
        checkOutput("sat_dec1", b_taken, 1);
        applyStimulus(0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        peekPc(32'h40);
        checkOutput("sat_dec2", b_taken, 0);
        repeat (2) applyStimulus(0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        applyStimulus(0, 32'h40, 1, 32'h40, 4'h0, 1, 0);
        peekPc(32'h40);
        checkOutput("sat_floor", b_taken, 0);

        // Speculative shifts, then recovery in the same cycle as a lookup
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h80, 1, 32'h80, 4'b0110, 1, 1);
        peekPc(32'h40);
        checkOutput("recover_ghr", g_ghr, 4'b1101);

        // Gshare entry 0x10 ^ 0xD = 0x1D trained via the recovered history
        repeat (2) applyStimulus(0, 32'h40, 1, 32'h40, 4'hD, 1, 0);
        peekPc(32'h40);
        checkOutput("gshare_40", g_taken, 1);
        peekPc(32'h44);
        checkOutput("gshare_44", g_taken, 0);

        // Collision: lookup and update of the same entry in one cycle
        applyStimulus(0, 32'h60, 1, 32'h60, 4'hD, 1, 0);
        applyStimulus(0, 32'h60, 1, 32'h60, 4'hD, 1, 0);
        applyStimulus(0, 32'h60, 0, 0, 0, 0, 0);

        // Randomised traffic with a reset pulse in the middle
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ppc;
            logic [31:0] upc;
            ppc = ($urandom & 32'hFFFF_FF00) | (32'h40 + (32'($urandom_range(0, 15)) << 2));
            upc = ($urandom & 32'hFFFF_FF00) | (32'h40 + (32'($urandom_range(0, 15)) << 2));
            if (n == 300) begin
                pred_valid = 1'b1;
                upd_valid  = 1'b1;
                upd_taken  = 1'b1;
                upd_mispredict = 1'b1;
                #2;
                reset = 1'b1;
                #1;
                modelReset();
                checkOutput("midrst_g_ghr",      g_ghr,      0);
                checkOutput("midrst_g_branches", g_branches, 0);
                checkOutput("midrst_b_branches", b_branches, 0);
                for (int i = 0; i < 16; i++) begin
                    pred_pc = 32'h40 + 32'(i << 2);
                    #0.1;
                    checkOutput("midrst_g_taken", g_taken, 0);
                    checkOutput("midrst_b_taken", b_taken, 0);
                end
                @(posedge clk);
                #1;
                checkAll();
                reset = 1'b0;
            end
            applyStimulus(1'($urandom), ppc, 1'($urandom_range(0, 2) != 0), upc,
                          4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
